fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end that replaces the bare PC register and next-PC mux in the pipeline top level.
- Generates fetch addresses and issues them to a synchronous instruction RAM with 1-cycle read latency.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO and presents them to decode through a valid/ready handshake.
- Supports branch/jump redirect with full flush, including killing an in-flight read. Decode stalls become back-pressure instead of PC freezing.

Parameters:
- ADDR_W, 32, PC and fetch address width.
- DATA_W, 32, instruction width.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 1, PC increment per fetch (1 = word-addressed RAM, 4 = byte-addressed).

Ports:
- CLOCK  in  1  single clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- imem_req  out  1  read request this cycle.
- imem_addr  out  ADDR_W  read address; meaningful only when imem_req=1.
- imem_data  in  DATA_W  read data; valid in the cycle after the request.
- redirect  in  1  branch/jump taken; flush and restart.
- redirect_pc  in  ADDR_W  restart address; sampled when redirect=1.
- deq_valid  out  1  head entry available.
- deq_ready  in  1  decode accepts head entry.
- deq_instr  out  DATA_W  head instruction.
- deq_pc  out  ADDR_W  PC of head instruction.
- count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset is asynchronous and active-high. While RESET=1:
  - pc=RESET_PC, count=0, rd/wr pointers=0, inflight=0.
  - imem_req=0, deq_valid=0, deq_instr=0, deq_pc=0.
- State registers:
  - pc: next fetch address.
  - inflight: 1 bit, a request was issued last cycle.
  - inflight_pc: PC of that request.
  - kill: in-flight response must be discarded.
  - FIFO storage, wr_ptr, rd_ptr, count.
- Issue rule (combinational):
  - imem_req = !RESET && !redirect && (count + inflight) < DEPTH.
  - Credits count both occupied and in-flight entries, so a returning word always has a free slot and the FIFO never overflows.
  - imem_addr = pc.
  - On issue: pc <= pc + PC_STEP (wraps modulo 2^ADDR_W), inflight <= 1, inflight_pc <= pc. Otherwise inflight <= 0.
- Response:
  - If inflight=1 and kill=0, write {imem_data, inflight_pc} at wr_ptr and increment wr_ptr.
  - If kill=1, drop the response and clear kill.
- Dequeue:
  - Fires when deq_valid && deq_ready; increments rd_ptr.
  - deq_valid = (count != 0). deq_instr and deq_pc are read combinationally from rd_ptr.
- Count: count <= count + write − dequeue. Simultaneous write and dequeue leaves count unchanged. Pointers wrap modulo DEPTH.
- Redirect (cycle t), highest priority:
  - Dequeue at t is honoured: decode has taken the word.
  - At edge t: FIFO cleared (count=0, wr_ptr=rd_ptr=0), pc <= redirect_pc.
  - kill <= inflight: a request issued at t−1 returns at t and is dropped because it is not written.
  - No request at t.
  - t+1: imem_req with imem_addr=redirect_pc. t+2: data written. t+3: deq_valid=1 with deq_pc=redirect_pc.
- Redirect on consecutive cycles: the last one wins; each flushes again.
- Reset deassert at cycle 0: request of RESET_PC at cycle 0, write at cycle 1, deq_valid at cycle 2.
- Full: count + inflight = DEPTH ⇒ no request. A dequeue frees a credit; the request re-issues the following cycle (credit from registered count).
- Steady state with deq_ready=1: one instruction per cycle, no bubbles.
- RESET mid-operation: immediate clear. Any response from the pre-reset request is ignored because inflight=0.

Test Plan:
- Reset release, RESET_PC=0, deq_ready=1, imem_data=addr+0x100 → deq_pc 0,1,2,3… and deq_instr 0x100,0x101… from cycle 2, one per cycle.
- deq_ready=0 for 10 cycles, DEPTH=4 → exactly 4 requests (addresses 0–3), count=4, imem_req=0. Raise deq_ready → PCs 0,1,2,3,4 delivered in order with no gap or duplicate.
- Full FIFO plus redirect to 0x40 in the same cycle as a dequeue → that dequeue accepted, count=0 next cycle, request 0x40 at t+1, deq_pc=0x40 at t+3, no stale PCs delivered.
- Redirect to 0x80 in the cycle after a request to 0x5 → data for 0x5 discarded, first delivered PC = 0x80.
- PC_STEP=4, ADDR_W=8, RESET_PC=0xF8 → addresses 0xF8, 0xFC, 0x00, 0x04 (wrap).
- Assert RESET for one cycle while count=3 and inflight=1 → all outputs zero immediately. After release, first deq_pc=RESET_PC and count never exceeds DEPTH.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end with sync-RAM issue, credit-based FIFO and redirect flush.
module fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int PC_STEP = 1,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              CLOCK,
  input  logic              RESET,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [DATA_W-1:0] deq_instr,
  output logic [ADDR_W-1:0] deq_pc,
  output logic [CW-1:0]     count
);
  logic [ADDR_W-1:0] pc, inflightPc;
  logic inflight, kill, write, deq;
  logic [PW-1:0] wrPtr, rdPtr;
  logic [CW:0] credits;
  logic [DATA_W-1:0] instrMem [DEPTH];
  logic [ADDR_W-1:0] pcMem [DEPTH];

  // In-flight requests hold a slot so a returning word always fits.
  assign credits = {1'b0, count} + (CW+1)'(inflight);
  assign imem_req = !RESET && !redirect && credits < (CW+1)'(DEPTH);
  assign imem_addr = pc;
  assign write = inflight && !kill;
  assign deq_valid = count != '0;
  assign deq = deq_valid && deq_ready;
  assign deq_instr = deq_valid ? instrMem[rdPtr] : '0;
  assign deq_pc = deq_valid ? pcMem[rdPtr] : '0;

  always_ff @(posedge CLOCK) begin
    if (write) begin
      instrMem[wrPtr] <= imem_data;
      pcMem[wrPtr] <= inflightPc;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      pc <= RESET_PC;
      inflight <= 1'b0;
      inflightPc <= '0;
      kill <= 1'b0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (redirect) begin
      pc <= redirect_pc;
      inflight <= 1'b0;
      kill <= inflight;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      inflight <= imem_req;
      kill <= 1'b0;
      if (imem_req) begin
        pc <= pc + ADDR_W'(PC_STEP);
        inflightPc <= pc;
      end
      if (write) wrPtr <= wrPtr + 1'b1;
      if (deq) rdPtr <= rdPtr + 1'b1;
      count <= count + CW'(write) - CW'(deq);
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random checks of fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  logic imemReq, redirect, deqValid, deqReady;
  logic [31:0] imemAddr, imemData, redirectPc, deqInstr, deqPc;
  logic [2:0] count;
  logic imemReq2, deqValid2;
  logic [7:0] imemAddr2, deqPc2;
  logic [31:0] deqInstr2;
  logic [2:0] count2;
  int tests = 0;
  int fails = 0;
  logic [31:0] mQ[$];
  logic [31:0] mPc, mPendPc;
  bit mPend, mKill, found;

  fetch_queue dut (
    .CLOCK(CLOCK), .RESET(RESET), .imem_req(imemReq), .imem_addr(imemAddr),
    .imem_data(imemData), .redirect(redirect), .redirect_pc(redirectPc),
    .deq_valid(deqValid), .deq_ready(deqReady), .deq_instr(deqInstr),
    .deq_pc(deqPc), .count(count)
  );

  fetch_queue #(.ADDR_W(8), .PC_STEP(4), .RESET_PC(8'hF8)) dut2 (
    .CLOCK(CLOCK), .RESET(RESET), .imem_req(imemReq2), .imem_addr(imemAddr2),
    .imem_data(32'h0), .redirect(1'b0), .redirect_pc(8'h0),
    .deq_valid(deqValid2), .deq_ready(1'b1), .deq_instr(deqInstr2),
    .deq_pc(deqPc2), .count(count2)
  );

  always #5 CLOCK = ~CLOCK;

  // Synchronous instruction RAM: word at address a is a + 0x100.
  always @(posedge CLOCK) imemData <= imemAddr + 32'h100;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mQ.delete();
    mPc = 32'h0;
    mPend = 1'b0;
    mKill = 1'b0;
  endtask

  task automatic resetCheck();
    check("rst_req", 64'(imemReq), 64'd0);
    check("rst_valid", 64'(deqValid), 64'd0);
    check("rst_instr", 64'(deqInstr), 64'd0);
    check("rst_pc", 64'(deqPc), 64'd0);
    check("rst_count", 64'(count), 64'd0);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic tick(input bit r, input logic [31:0] rp, input bit rdy);
    bit expReq, expValid;
    redirect = r;
    redirectPc = rp;
    deqReady = rdy;
    #1;
    expReq = !r && (mQ.size() + int'(mPend)) < 4;
    expValid = mQ.size() != 0;
    check("req", 64'(imemReq), 64'(expReq));
    if (expReq) check("addr", 64'(imemAddr), 64'(mPc));
    check("valid", 64'(deqValid), 64'(expValid));
    check("deq_pc", 64'(deqPc), expValid ? 64'(mQ[0]) : 64'd0);
    check("deq_instr", 64'(deqInstr), expValid ? 64'(mQ[0] + 32'h100) : 64'd0);
    check("count", 64'(count), 64'(mQ.size()));
    @(posedge CLOCK);
    if (r) begin
      mQ.delete();
      mPc = rp;
      mKill = mPend;
      mPend = 1'b0;
    end else begin
      if (expValid && rdy) void'(mQ.pop_front());
      if (mPend && !mKill) mQ.push_back(mPendPc);
      mKill = 1'b0;
      mPend = expReq;
      if (expReq) begin
        mPendPc = mPc;
        mPc = mPc + 32'd1;
      end
    end
    @(negedge CLOCK);
  endtask

  initial begin
    redirect = 1'b0;
    redirectPc = '0;
    deqReady = 1'b0;
    modelReset();
    @(negedge CLOCK);
    #1 resetCheck();
    @(negedge CLOCK);
    RESET = 1'b0;
    // Streaming from reset; the byte-stepped instance must wrap its address.
    for (int i = 0; i < 12; i++) begin
      if (i < 4) begin
        #1;
        check("wrap_req", 64'(imemReq2), 64'd1);
        check("wrap_addr", 64'(imemAddr2), 64'(8'(8'hF8 + 8'(4 * i))));
      end
      tick(1'b0, 32'h0, 1'b1);
    end
    // Back-pressure until full.
    for (int i = 0; i < 10; i++) tick(1'b0, 32'h0, 1'b0);
    #1;
    check("full_count", 64'(count), 64'd4);
    check("full_req", 64'(imemReq), 64'd0);
    for (int i = 0; i < 8; i++) tick(1'b0, 32'h0, 1'b1);
    // Redirect on a full FIFO together with a dequeue.
    for (int i = 0; i < 8; i++) tick(1'b0, 32'h0, 1'b0);
    tick(1'b1, 32'h40, 1'b1);
    #1 check("flush_count", 64'(count), 64'd0);
    for (int i = 0; i < 6; i++) tick(1'b0, 32'h0, 1'b1);
    // Kill the in-flight read of 0x5.
    tick(1'b1, 32'h5, 1'b1);
    tick(1'b0, 32'h0, 1'b1);
    tick(1'b1, 32'h80, 1'b1);
    tick(1'b0, 32'h0, 1'b1);
    tick(1'b0, 32'h0, 1'b1);
    #1 check("kill_first_pc", 64'(deqPc), 64'h80);
    for (int i = 0; i < 4; i++) tick(1'b0, 32'h0, 1'b1);
    // Back-to-back redirects: last one wins.
    tick(1'b1, 32'h10, 1'b1);
    tick(1'b1, 32'h20, 1'b1);
    tick(1'b1, 32'h30, 1'b1);
    for (int i = 0; i < 6; i++) tick(1'b0, 32'h0, 1'b1);
    // Random traffic.
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0);
    // Reset while count=3 and a read is in flight.
    tick(1'b1, 32'h200, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1'b0, 32'h0, 1'b0);
      found = mQ.size() == 3 && mPend;
    end
    check("midreset_reached", 64'(found), 64'd1);
    RESET = 1'b1;
    modelReset();
    #1 resetCheck();
    @(negedge CLOCK);
    #1 resetCheck();
    RESET = 1'b0;
    #1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 32'h0, i > 8);
      check("count_bound", 64'(count <= 3'd4), 64'd1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
